// File: rtl/xor_scrambler.sv
// xor_scrambler: LFSR keystream XOR scrambler/descrambler with a valid/ready
// handshake and one output register stage. Additive (MULT=0) or
// self-synchronous multiplicative (MULT=1) operation.
module xor_scrambler #(
  parameter int unsigned       DATA_W = 8,
  parameter int unsigned       LFSR_W = 16,
  parameter logic [LFSR_W-1:0] POLY   = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1,
  parameter int unsigned       MULT   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_val,
  input  logic              descr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [15:0]       beat_cnt
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_next;
  logic [DATA_W-1:0] beat_out;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic [15:0]       cnt_q;
  logic              accept;

  // Seed loading blocks acceptance so the LFSR has a single writer per cycle.
  assign in_ready = !rst && !seed_load && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign beat_cnt  = cnt_q;

  // Walk the LFSR DATA_W bit steps, LSB first, producing the beat and next state.
  always_comb begin
    logic [LFSR_W-1:0] walk;
    logic              fb;
    logic              shift_in;
    walk     = state_q;
    beat_out = '0;
    fb       = 1'b0;
    shift_in = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      fb          = ^(walk & POLY);
      beat_out[i] = in_data[i] ^ fb;
      if (MULT == 0)
        shift_in = fb;
      else if (descr)
        shift_in = in_data[i];
      else
        shift_in = beat_out[i];
      walk = {walk[LFSR_W-2:0], shift_in};
    end
    state_next = walk;
  end

  // LFSR state, output register and accepted-beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEED;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      if (seed_load)
        state_q <= (seed_val == '0) ? SEED : seed_val;
      else if (accept)
        state_q <= state_next;

      if (accept) begin
        out_data_q  <= beat_out;
        out_valid_q <= 1'b1;
        cnt_q       <= cnt_q + 16'd1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule
